sfp_seq: RTL
============

# sfp_seq

Sequencer that drives one `sfp_row` instance through a complete normalization of up to 2^addr_w psum rows. It streams rows from the psum SRAM twice: once with `acc` so the row accumulates per-row abs-sums, and once with `div` so it divides. Between the two passes it runs an optional ready handshake with the peer core so both cores' sum FIFOs are filled before division. It then quantizes the normalized `sfp_out` lanes to `bw` bits and issues them as output-SRAM writes.

## Interface
- `col`, default 8: lanes per row.
- `bw`, default 8: output lane width.
- `bw_psum`, default 20: psum lane width (2*bw+4).
- `addr_w`, default 4: row address width. Maximum rows is 2^addr_w, which matches the depth-16 sum FIFOs.
- `clk`, input, 1: the only clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: one-cycle pulse that begins a job. It is accepted only in IDLE.
- `num_rows`, input, addr_w+1: row count. It is sampled on an accepted `start`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at the end of a job.
- `mem_rd`, output, 1: psum SRAM read enable. Read latency is 1 cycle.
- `mem_addr`, output, addr_w: psum SRAM read address.
- `mem_rdata`, input, col*bw_psum: psum SRAM read data.
- `sfp_in`, output, col*bw_psum: drives `sfp_row.sfp_in`. It equals `mem_rdata` combinationally.
- `acc`, output, 1: drives `sfp_row.acc`.
- `div`, output, 1: drives `sfp_row.div`.
- `sfp_out`, input, col*bw_psum: normalized lanes from `sfp_row`.
- `peer_sync_out`, output, 1: tells the peer core that the local accumulate pass is complete.
- `peer_sync_in`, input, 1: the peer core's `peer_sync_out`.
- `out_wr`, output, 1: output SRAM write enable.
- `out_addr`, output, addr_w: output SRAM write address.
- `out_data`, output, col*bw: quantized lanes. Lane i occupies bits [bw*(i+1)-1 : bw*i].

## Operation
FSM states: IDLE, ACC_RD, ACC_DRAIN, SYNC, DIV_RD, DIV_DRAIN, WB_DRAIN, DONE.
- **IDLE**
  - On `start`: latch N = min(`num_rows`, 2^addr_w) and clear the row counter.
  - If N==0, go to DONE; otherwise go to ACC_RD.
- **ACC_RD**
  - Assert `mem_rd` with `mem_addr` = counter, and increment the counter.
  - After N reads, clear the counter and go to ACC_DRAIN.
- **ACC_DRAIN**
  - Wait one cycle for the last read data, then go to SYNC.
- **SYNC**
  - `peer_sync_out` is high for every cycle spent in SYNC.
  - Exit to DIV_RD on the first cycle in which `peer_sync_in`==1.
  - If `peer_sync_in` is already high on entry, SYNC lasts exactly 1 cycle.
- **DIV_RD**
  - Same read sweep as ACC_RD, addresses 0..N-1.
  - Then DIV_DRAIN (1 cycle), then WB_DRAIN (1 cycle), then DONE.
- **DONE**
  - `done`=1 for 1 cycle, then IDLE.
- **acc / div generation**
  - `acc` is `mem_rd` registered, but only for reads issued in ACC_RD.
  - `div` is `mem_rd` registered, but only for reads issued in DIV_RD.
  - This makes `acc`/`div` coincide exactly with valid `sfp_in`.
- **Writeback**
  - `out_wr` is `div` registered (one `sfp_row` output latency).
  - `out_addr` is the row address delayed by 2 cycles from `mem_addr`.
- **Quantization** (per lane, unsigned)
  - Lane value v = `sfp_out` lane [bw_psum-1:0].
  - `out_data` lane = (v > 2^bw-1) ? 2^bw-1 : v[bw-1:0].
  - Saturation is needed because v==256 occurs when one lane holds the whole sum.
- `start` while `busy` is ignored.
- `reset` in any state forces IDLE next cycle, clears the counters, and deasserts all outputs. No partial writes are issued afterward.

## Timing
- All outputs are 0 out of reset, except `sfp_in`, which follows `mem_rdata`.
- With `start` at cycle T and N≥1:
  - `mem_rd` is high in cycles T+1..T+N.
  - `acc` is high in cycles T+2..T+N+1.
  - SYNC is entered at T+N+2.
- If SYNC is entered at cycle S and exited at cycle S+k (k≥0 extra wait cycles):
  - `mem_rd` is high in cycles S+k+1..S+k+N.
  - `div` is high in cycles S+k+2..S+k+N+1.
  - `out_wr` is high in cycles S+k+3..S+k+N+2.
  - `done` is high at cycle S+k+N+3.
- Minimum job length is 2N+5 cycles from `start` to `done` (SYNC lasting 1 cycle).
- With N==0: `busy` is high at T+1 and `done` is high at T+1. There are no memory, `acc`, `div`, or `out_wr` pulses.

## Configuration
- `SFP_PEER_SYNC_EN` defined:
  - The SYNC state and handshake behave as described above.
- `SFP_PEER_SYNC_EN` undefined:
  - SYNC is bypassed; ACC_DRAIN goes directly to DIV_RD, saving one cycle.
  - `peer_sync_out` is tied to 0 and `peer_sync_in` is ignored.
  - All other timing shifts earlier by one cycle.

## Test plan
- Reset: assert `reset` for 2 cycles → `busy`=`done`=`mem_rd`=`acc`=`div`=`out_wr`=0 and `peer_sync_out`=0.
- Single-stream normalization:
  - Setup: N=4; `peer_sync_in` tied 1; row 0 = lanes {64,-64,0,0,0,0,0,0} and the other rows arbitrary.
  - Stimulus: pulse `start`.
  - Check: `acc` pattern for 4 cycles, then `div` for 4 cycles.
  - Check: `out_addr` sequence 0,1,2,3.
  - Check: `done` at cycle 2N+5 = 13 after `start`.
- Saturation:
  - Setup: a row with lane0=100 and all other lanes 0, so the `sfp_row` result v=256.
  - Check: `out_data` lane0=255 and the other lanes=0.
  - Setup: a row where a lane value produces v=128.
  - Check: `out_data` for that lane is 128.
- Peer stall:
  - Setup: hold `peer_sync_in`=0 for 10 cycles after SYNC entry, then raise it.
  - Check: `peer_sync_out` is high for 11 cycles.
  - Check: no `mem_rd` during the stall.
  - Check: `div` starts 2 cycles after the exit.
- Boundaries:
  - `num_rows`=0 → `done` at T+1 and no reads.
  - `num_rows`=20 → clamped to 16 reads, addresses 0..15.
  - `start` pulsed mid-job → ignored; the job completes unchanged.
- Reset mid-operation:
  - Stimulus: `reset` at the 2nd cycle of DIV_RD.
  - Check: IDLE next cycle and no further `out_wr`.
  - Check: a fresh `start` then completes a normal job.

Source files
------------

// File: rtl/sfp_seq_if.sv
// sfp_seq_if: bundle of the job-control, psum-SRAM, sfp_row, peer-sync and
// output-SRAM signals of the sfp_seq normalization sequencer.
//   master : the sequencer (drives busy/done, SRAM reads, acc/div, writes)
//   slave  : the surroundings (start/num_rows, read data, sfp_row result,
//            peer handshake)
interface sfp_seq_if #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 20,
  parameter int addr_w  = 4
);
  logic                     start;
  logic [addr_w:0]          num_rows;
  logic                     busy;
  logic                     done;
  logic                     mem_rd;
  logic [addr_w-1:0]        mem_addr;
  logic [col*bw_psum-1:0]   mem_rdata;
  logic [col*bw_psum-1:0]   sfp_in;
  logic                     acc;
  logic                     div;
  logic [col*bw_psum-1:0]   sfp_out;
  logic                     peer_sync_out;
  logic                     peer_sync_in;
  logic                     out_wr;
  logic [addr_w-1:0]        out_addr;
  logic [col*bw-1:0]        out_data;

  modport master (
    input  start, num_rows, mem_rdata, sfp_out, peer_sync_in,
    output busy, done, mem_rd, mem_addr, sfp_in, acc, div,
           peer_sync_out, out_wr, out_addr, out_data
  );

  modport slave (
    output start, num_rows, mem_rdata, sfp_out, peer_sync_in,
    input  busy, done, mem_rd, mem_addr, sfp_in, acc, div,
           peer_sync_out, out_wr, out_addr, out_data
  );
endinterface

// File: rtl/sfp_seq.sv
// sfp_seq: drives one sfp_row through a normalization of up to 2^addr_w psum
// rows: an accumulate sweep over the psum SRAM, an optional peer-core ready
// handshake, a divide sweep, then saturating quantization of the sfp_row
// result into output-SRAM writes.
//
// Ports
//   clk   : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : sfp_seq_if.master (start/num_rows/busy/done, psum SRAM read port,
//           sfp_row acc/div/sfp_in/sfp_out, peer_sync_out/in, output SRAM
//           write port)
//
// Build option
//   SFP_PEER_SYNC_EN : when defined, the SYNC state waits for peer_sync_in
//                      between the two sweeps; when undefined, SYNC is
//                      skipped, peer_sync_out is 0 and peer_sync_in unused.
//
// state       | meaning
// ------------+------------------------------------------------
// IDLE        | waiting for start
// ACC_RD      | reading rows 0..N-1 for the accumulate pass
// ACC_DRAIN   | last accumulate read data in flight
// SYNC        | peer_sync_out high, waiting for peer_sync_in
// DIV_RD      | reading rows 0..N-1 for the divide pass
// DIV_DRAIN   | last divide read data in flight
// WB_DRAIN    | last sfp_row result being written
// DONE        | done pulse
module sfp_seq #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 20,
  parameter int addr_w  = 4
) (
  input  logic          clk,
  input  logic          reset,
  sfp_seq_if.master     bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACC_RD    = 3'd1;
  localparam logic [2:0] S_ACC_DRAIN = 3'd2;
  localparam logic [2:0] S_SYNC      = 3'd3;
  localparam logic [2:0] S_DIV_RD    = 3'd4;
  localparam logic [2:0] S_DIV_DRAIN = 3'd5;
  localparam logic [2:0] S_WB_DRAIN  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [addr_w:0]    MAX_ROWS = {1'b1, {addr_w{1'b0}}};
  localparam logic [addr_w:0]    ROWS_ONE = {{addr_w{1'b0}}, 1'b1};
  localparam logic [addr_w-1:0]  CNT_ONE  = {{(addr_w-1){1'b0}}, 1'b1};
  localparam logic [bw_psum-1:0] LANE_MAX = {{(bw_psum-bw){1'b0}}, {bw{1'b1}}};

  logic [2:0]        r_state;
  logic [addr_w:0]   r_rows;
  logic [addr_w-1:0] r_cnt;
  logic [addr_w-1:0] r_addr_d1;
  logic [addr_w-1:0] r_addr_d2;
  logic              r_acc;
  logic              r_div;
  logic              r_out_wr;

  logic              w_rd_acc;
  logic              w_rd_div;
  logic              w_last;

  assign w_rd_acc = (r_state == S_ACC_RD);
  assign w_rd_div = (r_state == S_DIV_RD);
  // r_rows is never 0 in a read state, so N-1 cannot wrap.
  assign w_last   = ({1'b0, r_cnt} == (r_rows - ROWS_ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_cnt     <= '0;
      r_addr_d1 <= '0;
      r_addr_d2 <= '0;
      r_acc     <= 1'b0;
      r_div     <= 1'b0;
      r_out_wr  <= 1'b0;
    end else begin
      // acc/div line up with the 1-cycle SRAM latency; out_wr with sfp_row's.
      r_acc     <= w_rd_acc;
      r_div     <= w_rd_div;
      r_out_wr  <= r_div;
      r_addr_d1 <= r_cnt;
      r_addr_d2 <= r_addr_d1;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rows  <= (bus.num_rows > MAX_ROWS) ? MAX_ROWS : bus.num_rows;
            r_cnt   <= '0;
            r_state <= (bus.num_rows == '0) ? S_DONE : S_ACC_RD;
          end
        end
        S_ACC_RD: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_ACC_DRAIN;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
`ifdef SFP_PEER_SYNC_EN
        S_ACC_DRAIN: r_state <= S_SYNC;
        S_SYNC: begin
          if (bus.peer_sync_in) r_state <= S_DIV_RD;
        end
`else
        S_ACC_DRAIN: r_state <= S_DIV_RD;
`endif
        S_DIV_RD: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DIV_DRAIN;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        S_DIV_DRAIN: r_state <= S_WB_DRAIN;
        S_WB_DRAIN:  r_state <= S_DONE;
        S_DONE:      r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.mem_rd   = w_rd_acc | w_rd_div;
  assign bus.mem_addr = r_cnt;
  assign bus.sfp_in   = bus.mem_rdata;
  assign bus.acc      = r_acc;
  assign bus.div      = r_div;
  assign bus.out_wr   = r_out_wr;
  assign bus.out_addr = r_addr_d2;

`ifdef SFP_PEER_SYNC_EN
  assign bus.peer_sync_out = (r_state == S_SYNC);
`else
  logic w_unused_peer_sync_in;
  assign w_unused_peer_sync_in = bus.peer_sync_in;
  assign bus.peer_sync_out     = 1'b0;
`endif

  // A lane holding the entire row sum normalizes to 2^bw, one past the
  // largest representable code, so lanes saturate instead of truncating.
  for (genvar gi = 0; gi < col; gi++) begin : g_quant
    logic [bw_psum-1:0] w_v;
    assign w_v = bus.sfp_out[gi*bw_psum +: bw_psum];
    assign bus.out_data[gi*bw +: bw] = (w_v > LANE_MAX) ? {bw{1'b1}} : w_v[bw-1:0];
  end

endmodule
